// File: rtl/crc_job_arbiter.sv
// crc_job_arbiter: two-requester round-robin front end for a single CRC engine.
// One job is outstanding at a time: accept -> issue start pulse -> wait for the
// engine (bounded by TIMEOUT cycles) -> hold the response until it is taken.
module crc_job_arbiter #(
   parameter int unsigned TIMEOUT = 127
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [59:0] req0_message,
   input  logic        req0_mode,
   input  logic        req0_crc,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [59:0] req1_message,
   input  logic        req1_mode,
   input  logic        req1_crc,
   output logic        eng_start,
   output logic [59:0] eng_message,
   output logic        eng_mode,
   output logic        eng_crc,
   input  logic        eng_done,
   input  logic [59:0] eng_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [59:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   localparam logic [7:0] TMO = TIMEOUT[7:0];

   state_t      state_q, state_d;
   logic        rr_q, rr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        eng_start_q, eng_start_d;
   logic [59:0] eng_message_q, eng_message_d;
   logic        eng_mode_q, eng_mode_d;
   logic        eng_crc_q, eng_crc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_id_q, rsp_id_d;
   logic [59:0] rsp_data_q, rsp_data_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        busy_q, busy_d;
   logic        grant;

   // Grant: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = ~rr_q;
      if (req0_valid && !req1_valid)      grant = 1'b0;
      else if (req1_valid && !req0_valid) grant = 1'b1;
   end

   assign req0_ready = (state_q == ST_IDLE) && (grant == 1'b0);
   assign req1_ready = (state_q == ST_IDLE) && (grant == 1'b1);

   // Next-state and registered-output logic for the job FSM.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      cnt_d         = cnt_q;
      eng_start_d   = 1'b0;
      eng_message_d = eng_message_q;
      eng_mode_d    = eng_mode_q;
      eng_crc_d     = eng_crc_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req0_valid && req0_ready) begin
               eng_message_d = req0_message;
               eng_mode_d    = req0_mode;
               eng_crc_d     = req0_crc;
               rsp_id_d      = 1'b0;
               eng_start_d   = 1'b1;
               state_d       = ST_ISSUE;
            end else if (req1_valid && req1_ready) begin
               eng_message_d = req1_message;
               eng_mode_d    = req1_mode;
               eng_crc_d     = req1_crc;
               rsp_id_d      = 1'b1;
               eng_start_d   = 1'b1;
               state_d       = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // eng_done is tested first so it wins a same-cycle timeout.
            if (eng_done) begin
               rsp_data_d    = eng_result;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = ST_RESP;
            end else if (cnt_q + 8'd1 == TMO) begin
               rsp_data_d    = '1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rr_d        = rsp_id_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         rr_q          <= 1'b1;
         cnt_q         <= '0;
         eng_start_q   <= 1'b0;
         eng_message_q <= '0;
         eng_mode_q    <= 1'b0;
         eng_crc_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         cnt_q         <= cnt_d;
         eng_start_q   <= eng_start_d;
         eng_message_q <= eng_message_d;
         eng_mode_q    <= eng_mode_d;
         eng_crc_q     <= eng_crc_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign eng_start   = eng_start_q;
   assign eng_message = eng_message_q;
   assign eng_mode    = eng_mode_q;
   assign eng_crc     = eng_crc_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_crc_job_arbiter.sv
// Self-checking bench for crc_job_arbiter: directed scenarios plus random jobs,
// checked against a job-level model (grant rule, WAIT-cycle count, result).
module tb_crc_job_arbiter;

   localparam int TMO = 127;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [59:0] req0_message, req1_message;
   logic        req0_mode, req1_mode, req0_crc, req1_crc;
   logic        eng_start, eng_mode, eng_crc;
   logic [59:0] eng_message;
   logic        eng_done;
   logic [59:0] eng_result;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_timeout, busy;
   logic [59:0] rsp_data;

   int passes = 0;
   int total  = 0;
   bit last   = 1'b1;

   crc_job_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_message(req0_message),
      .req0_mode(req0_mode), .req0_crc(req0_crc),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_message(req1_message),
      .req1_mode(req1_mode), .req1_crc(req1_crc),
      .eng_start(eng_start), .eng_message(eng_message), .eng_mode(eng_mode), .eng_crc(eng_crc),
      .eng_done(eng_done), .eng_result(eng_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [59:0] rnd60();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[59:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One complete job; called at a negedge with the DUT idle.
   task automatic run_job(input logic v0, input logic v1,
                          input logic [59:0] m0, input logic [59:0] m1,
                          input logic md0, input logic md1, input logic c0, input logic c1,
                          input int dd, input logic [59:0] res, input int rd, input logic bp1);
      bit          g;
      logic [59:0] em, exp_data;
      logic        emd, ec, exp_to;
      int          waits, exp_waits;
      bit          ok, started;
      logic [63:0] snap;
      req0_valid = v0; req0_message = m0; req0_mode = md0; req0_crc = c0;
      req1_valid = v1; req1_message = m1; req1_mode = md1; req1_crc = c1;
      if (v0 && !v1)      g = 1'b0;
      else if (v1 && !v0) g = 1'b1;
      else                g = ~last;
      em  = g ? m1 : m0;
      emd = g ? md1 : md0;
      ec  = g ? c1 : c0;
      #1;
      chk("ready0", 64'(req0_ready), 64'(g == 1'b0));
      chk("ready1", 64'(req1_ready), 64'(g == 1'b1));
      @(negedge clk);
      if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      chk("issue_start", 64'(eng_start), 64'd1);
      chk("issue_msg", 64'(eng_message), 64'(em));
      chk("issue_mode_crc", 64'({eng_mode, eng_crc}), 64'({emd, ec}));
      chk("issue_busy_ready", 64'({busy, req0_ready, req1_ready}), 64'b100);
      eng_done   = 1'($urandom_range(0, 1));
      eng_result = rnd60();
      @(negedge clk);
      chk("wait_start_low", 64'(eng_start), 64'd0);
      waits = 0; started = 1'b0;
      for (int k = 0; k < 400; k++) begin
         eng_done   = (k == dd);
         eng_result = (k == dd) ? res : rnd60();
         @(negedge clk);
         waits++;
         if (eng_start) started = 1'b1;
         if (rsp_valid) break;
      end
      eng_done = 1'b0;
      exp_to    = (dd >= TMO);
      exp_waits = exp_to ? TMO : dd + 1;
      exp_data  = exp_to ? '1 : res;
      chk("wait_cycles", 64'(waits), 64'(exp_waits));
      chk("single_start", 64'(started), 64'd0);
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_data", 64'(rsp_data), 64'(exp_data));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
      chk("eng_hold", 64'({eng_message, eng_mode, eng_crc}), 64'({em, emd, ec}));
      if (bp1) begin
         req1_valid = 1'b1; req1_message = rnd60();
      end
      ok = 1'b1;
      snap = 64'({rsp_id, rsp_timeout, rsp_data});
      for (int i = 0; i < rd; i++) begin
         eng_done   = 1'($urandom_range(0, 1));
         eng_result = rnd60();
         @(negedge clk);
         if (64'({rsp_id, rsp_timeout, rsp_data}) !== snap || rsp_valid !== 1'b1 ||
             req0_ready !== 1'b0 || req1_ready !== 1'b0) ok = 1'b0;
      end
      eng_done = 1'b0;
      chk("rsp_hold", 64'(ok), 64'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_released", 64'({rsp_valid, busy}), 64'b00);
      last = g;
      if (bp1) chk("bp_req1_ready", 64'(req1_ready), 64'(!req0_valid || last == 1'b0));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      bit ok;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_message = '0; req1_message = '0;
      req0_mode = 1'b0; req1_mode = 1'b0; req0_crc = 1'b0; req1_crc = 1'b0;
      eng_done = 1'b0; eng_result = '0; rsp_ready = 1'b0;
      #12;
      chk("reset_ctl", 64'({eng_start, rsp_valid, rsp_id, rsp_timeout, busy}), 64'd0);
      chk("reset_data", 64'({eng_mode, eng_crc, eng_message}), 64'd0);
      chk("reset_rsp", 64'(rsp_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Contention from reset: expected order 0,1,0,1.
      for (int j = 0; j < 4; j++)
         run_job(1'b1, 1'b1, rnd60(), rnd60(), 1'b0, 1'b1, 1'b1, 1'b0,
                 $urandom_range(0, 6), rnd60(), 0, 1'b0);

      // Single job with fixed message; result five cycles after start.
      run_job(1'b1, 1'b0, 60'h123456789ABCDEF, '0, 1'b0, 1'b0, 1'b0, 1'b0,
              4, 60'h0AB, 0, 1'b0);

      // Timeout with no engine response.
      run_job(1'b0, 1'b1, '0, rnd60(), 1'b0, 1'b1, 1'b0, 1'b1, 1000, '0, 1, 1'b0);

      // Done in the same cycle as the timeout.
      run_job(1'b1, 1'b0, rnd60(), '0, 1'b1, 1'b0, 1'b0, 1'b0,
              TMO - 1, 60'h5A5_A5A5_A5A5_A5A5, 0, 1'b0);

      // Backpressure with req1 waiting, then req1 accepted right after.
      run_job(1'b1, 1'b0, rnd60(), '0, 1'b0, 1'b0, 1'b1, 1'b0, 2, rnd60(), 10, 1'b1);
      run_job(1'b0, 1'b1, '0, rnd60(), 1'b0, 1'b0, 1'b0, 1'b1, 0, rnd60(), 0, 1'b0);

      // Random jobs.
      for (int j = 0; j < 20; j++) begin
         logic v0, v1;
         int   dd;
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         case ($urandom_range(0, 7))
            0:       dd = TMO - 1;
            1:       dd = TMO + $urandom_range(0, 50);
            default: dd = $urandom_range(0, 20);
         endcase
         run_job(v0, v1, rnd60(), rnd60(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 dd, rnd60(), $urandom_range(0, 3), 1'b0);
      end

      // Reset pulsed mid-WAIT: job discarded, pointer back to favour requester 0.
      req0_valid = 1'b1; req0_message = rnd60(); req0_mode = 1'b1; req0_crc = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctl", 64'({eng_start, rsp_valid, rsp_id, rsp_timeout, busy}), 64'd0);
      chk("midrst_data", 64'({eng_mode, eng_crc, eng_message}), 64'd0);
      chk("midrst_rsp", 64'(rsp_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < TMO + 20; i++) begin
         eng_done   = 1'($urandom_range(0, 1));
         eng_result = rnd60();
         @(negedge clk);
         if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      eng_done = 1'b0;
      chk("midrst_no_rsp", 64'(ok), 64'd1);
      last = 1'b1;
      run_job(1'b1, 1'b1, rnd60(), rnd60(), 1'b0, 1'b0, 1'b0, 1'b0, 3, rnd60(), 0, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   // Watchdog: the bench must end on its own.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
